pixel_store: RTL and testbench
==============================

# pixel_store

Frame-buffer and pixel-fetch block on the consuming side of the VGA coordinate stream. It accepts the `vgaX`/`vgaY` scan coordinates and drives 8-bit R/G/B to the video DAC. Each on-screen pixel is fetched from a 160×120, 4-bit indexed frame buffer, with every stored pixel covering a 4×4 block of display pixels. The MCU link updates the buffer through a byte-stream write port; bytes arrive already synchronized to this clock.

## Interface
Parameters:
- `FB_W`, default 160: frame-buffer width in stored pixels.
- `FB_H`, default 120: frame-buffer height in stored pixels.
- `SCALE_SHIFT`, default 2: log2 of the display-to-buffer scale; a display coordinate shifted right by this amount gives the buffer coordinate.
- `COLOR_BITS`, default 4: bits per stored pixel (palette index width).

Ports (name, direction, width, meaning):
- `clk`, in, 1: pixel clock (the 25.175 MHz VGA clock).
- `reset`, in, 1: asynchronous, active-high reset.
- `vgaX`, in, 10: current display column.
- `vgaY`, in, 10: current display row.
- `in_data`, in, 8: write-port byte.
- `in_valid`, in, 1: `in_data` is valid this cycle.
- `in_ready`, out, 1: block accepts a byte this cycle.
- `busy`, out, 1: a clear sweep is in progress.
- `r`, `g`, `b`, out, 8 each: pixel colour to the DAC.

## Operation
- A byte transfers on any cycle where `in_valid` and `in_ready` are both high. `in_ready` = !`busy`.
- Command parser FSM states: `IDLE`, `GOT_X`, `GOT_Y`, `CLR_COLOR`, `CLEARING`.
  - `IDLE` + byte ≠ 0xFF: latch x, go to `GOT_X`.
  - `IDLE` + byte = 0xFF: go to `CLR_COLOR`.
  - `GOT_X` + byte: latch y, go to `GOT_Y`.
  - `GOT_Y` + byte: write `byte[COLOR_BITS-1:0]` at address y*FB_W + x, go to `IDLE`.
  - `CLR_COLOR` + byte: latch the fill colour, clear the sweep counter, go to `CLEARING`.
  - `CLEARING`: write the fill colour to one address per cycle, from 0 to FB_W*FB_H−1, then go to `IDLE`. `busy` is high throughout this state.
- Out-of-range writes (x ≥ FB_W or y ≥ FB_H): all 3 bytes are consumed and no memory write occurs.
- Address is 15 bits. Compute y*FB_W as (y<<7)+(y<<5) for the default FB_W.
- Read path:
  - bx = vgaX>>SCALE_SHIFT, by = vgaY>>SCALE_SHIFT.
  - visible = (vgaX < 640) && (vgaY < 480).
  - Address = by*FB_W + bx.
- Palette rule for index i:
  - Component C ∈ {R=i[2], G=i[1], B=i[0]}.
  - C=1: component = 0xFF if i[3], else 0xAA.
  - C=0: component = 0x55 if i[3], else 0x00.
  - Examples: 0→000000, 7→AAAAAA, 8→555555, 15→FFFFFF, 4→AA0000.
- Non-visible coordinates output 000000.
- Memory is a simple dual-port RAM: one write port, one registered read port. On a same-cycle read and write to the same address, the read returns the old data.

## Timing
- Reset (asynchronous) forces the following:
  - `r`=`g`=`b`=0 and the read pipeline's visible flags cleared.
  - FSM enters `CLEARING` with fill colour 0 and sweep counter 0, so `busy`=1 and `in_ready`=0.
  - The sweep runs for FB_W*FB_H = 19200 cycles after reset deasserts. `busy` falls on the cycle after address 19199 is written.
- Reset mid-command or mid-sweep abandons any partial command and restarts the zero sweep.
- Read latency is exactly 2 cycles: `r`/`g`/`b` at cycle N+2 reflect `vgaX`/`vgaY` at cycle N. The visible flag is pipelined alongside the data. Downstream logic delays hsync/vsync/blank by 2 cycles to match.
- A memory write issued by a transfer in cycle N is visible to a read whose coordinates are sampled in cycle N+1 or later.
- The write port sustains 1 byte per cycle while not `busy`. A pixel write therefore takes 3 transfers; back-to-back commands need no idle cycles.
- The 0xFF clear byte is decoded only in `IDLE`. As an x/y/colour value it is ordinary data: x=0xFF is impossible, since 0xFF in `IDLE` always starts a clear; y=0xFF is simply out of range.
- During `CLEARING` the read path keeps running and may show partially cleared contents.

## Test plan
- Reset: `reset` pulse → `busy`=1 for exactly 19200 cycles after deassert, then `in_ready`=1. Reading any visible coordinate afterwards → RGB 000000.
- Pixel write: bytes 0x0A, 0x05, 0x0C → coordinates (40..43, 20..23) show FF5555 after 2-cycle latency; (44, 20) stays 000000.
- Clear: bytes 0xFF, 0x07 → `busy` for 19200 cycles and `in_ready`=0 throughout (stalled `in_valid` bytes are not consumed); then every visible pixel reads AAAAAA.
- Bounds: write x=0xA0 (160) or y=0x78 (120) → no memory change. Coordinates (640, 0) and (0, 480) → 000000 even if buffer address 0 is non-zero.
- Collision: read (0,0) in the same cycle as a write of colour 15 to (0,0) → old value output; the next sample of (0,0) → FFFFFF.
- Async reset asserted during the `GOT_Y` state → outputs 0 immediately with no clock edge. The pending write does not occur, and the zero sweep restarts.

Source files
------------

// File: rtl/pixel_store.sv
// 160x120 indexed frame buffer: byte-command write port, 4x-scaled VGA read path.
// Read latency 2 cycles; in_ready is low for the whole clear sweep (held bytes are not consumed).
module pixel_store #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int COLOR_BITS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vgaX,
  input  logic [9:0] vgaY,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int          DEPTH = FB_W * FB_H;
  localparam logic [14:0] LAST  = 15'(DEPTH - 1);
  localparam logic [14:0] FBW15 = 15'(FB_W);
  localparam logic [14:0] FBH15 = 15'(FB_H);

  typedef enum logic [2:0] {IDLE, GOT_X, GOT_Y, CLR_COLOR, CLEARING} state_t;

  state_t                  state_q;
  logic [7:0]              x_q, y_q;
  logic [COLOR_BITS-1:0]   fill_q;
  logic [14:0]             sweep_q;
  logic [COLOR_BITS-1:0]   mem_q [DEPTH];
  logic [COLOR_BITS-1:0]   rd_q;
  logic                    vis_q;
  logic [7:0]              r_q, g_q, b_q;

  logic                    xfer;
  logic                    pix_in_range;
  logic                    wr_en;
  logic [14:0]             wr_addr;
  logic [COLOR_BITS-1:0]   wr_dat;
  logic                    vis_d;
  logic [14:0]             bx, by, rd_addr;

  function automatic logic [14:0] row_base(input logic [14:0] y);
    if (FB_W == 160) return (y << 7) + (y << 5);
    else             return 15'(y * FB_W);
  endfunction

  function automatic logic [7:0] comp(input logic c, input logic hi);
    if (c) return hi ? 8'hFF : 8'hAA;
    else   return hi ? 8'h55 : 8'h00;
  endfunction

  function automatic logic [23:0] palette(input logic [3:0] i);
    return {comp(i[2], i[3]), comp(i[1], i[3]), comp(i[0], i[3])};
  endfunction

  assign busy     = (state_q == CLEARING);
  assign in_ready = !busy;
  assign xfer     = in_valid && in_ready;

  // Command parser; 0xFF is a clear opcode only when no command is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEARING;
      x_q     <= '0;
      y_q     <= '0;
      fill_q  <= '0;
      sweep_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (xfer) begin
          if (in_data == 8'hFF) state_q <= CLR_COLOR;
          else begin
            x_q     <= in_data;
            state_q <= GOT_X;
          end
        end
        GOT_X: if (xfer) begin
          y_q     <= in_data;
          state_q <= GOT_Y;
        end
        GOT_Y: if (xfer) state_q <= IDLE;
        CLR_COLOR: if (xfer) begin
          fill_q  <= in_data[COLOR_BITS-1:0];
          sweep_q <= '0;
          state_q <= CLEARING;
        end
        CLEARING: begin
          if (sweep_q == LAST) state_q <= IDLE;
          else                 sweep_q <= sweep_q + 15'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_in_range = ({7'b0, x_q} < FBW15) && ({7'b0, y_q} < FBH15);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = row_base({7'b0, y_q}) + {7'b0, x_q};
    wr_dat  = in_data[COLOR_BITS-1:0];
    if (state_q == CLEARING) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q;
      wr_dat  = fill_q;
    end else if (state_q == GOT_Y && xfer && pix_in_range) begin
      wr_en = 1'b1;
    end
  end

  assign bx      = 15'(vgaX >> SCALE_SHIFT);
  assign by      = 15'(vgaY >> SCALE_SHIFT);
  assign vis_d   = (vgaX < 10'd640) && (vgaY < 10'd480);
  assign rd_addr = vis_d ? row_base(by) + bx : 15'd0;

  // Read-before-write: a same-cycle collision returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
    rd_q <= mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_q <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      vis_q <= vis_d;
      if (vis_q) {r_q, g_q, b_q} <= palette(4'(rd_q));
      else       {r_q, g_q, b_q} <= 24'h0;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule

// File: tb/tb_pixel_store.sv
// Scoreboard bench for pixel_store: reads push expected RGB, a negedge monitor compares.
module tb_pixel_store;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] vgaX, vgaY;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, busy;
  logic [7:0] r, g, b;

  pixel_store dut (
    .clk(clk), .reset(reset), .vgaX(vgaX), .vgaY(vgaY),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] exp;
    string       name;
  } ent_t;

  ent_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      check(q[0].name, {8'h0, r, g, b}, {8'h0, q[0].exp});
      void'(q.pop_front());
    end
  end

  // Present a coordinate this cycle; its colour is due two edges later.
  task automatic rd(input int x, input int y, input logic [23:0] exp, input string name);
    vgaX = 10'(x);
    vgaY = 10'(y);
    q.push_back('{due: cyc + 2, exp: exp, name: name});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_step(input int x, input int y, input logic [23:0] exp, input string name);
    rd(x, y, exp, name);
    step(1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_sweep(input string name, input logic hold_byte);
    int n = 0;
    int rdy_seen = 0;
    in_valid = hold_byte;
    in_data  = 8'h55;
    while (busy && n < 20000) begin
      if (in_ready) rdy_seen++;
      step(1);
      n++;
    end
    in_valid = 1'b0;
    check(name, 32'(n), 32'd19200);
    check({name, "_rdy_low"}, 32'(rdy_seen), 32'd0);
    check({name, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    vgaX     = 10'd700;
    vgaY     = 10'd0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    #3;
    check("reset_rgb", {8'h0, r, g, b}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rdy", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_sweep("reset_sweep", 1'b0);

    rd_step(0, 0, 24'h000000, "post_reset_0_0");
    rd_step(639, 479, 24'h000000, "post_reset_639_479");
    rd_step(320, 240, 24'h000000, "post_reset_320_240");

    // Out-of-range x then y: bytes consumed, nothing written.
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h0F);
    send_byte(8'h05); send_byte(8'h78); send_byte(8'h0F);
    rd_step(0, 4, 24'h000000, "bound_x_row1");
    rd_step(0, 0, 24'h000000, "bound_x_origin");

    send_byte(8'h0A); send_byte(8'h05); send_byte(8'h0C);
    rd_step(40, 20, 24'hFF5555, "pix_40_20");
    rd_step(43, 23, 24'hFF5555, "pix_43_23");
    rd_step(41, 22, 24'hFF5555, "pix_41_22");
    rd_step(44, 20, 24'h000000, "pix_44_20");
    rd_step(39, 20, 24'h000000, "pix_39_20");
    rd_step(40, 24, 24'h000000, "pix_40_24");

    send_byte(8'hFF); send_byte(8'h07);
    check("clear_busy", {31'd0, busy}, 32'd1);
    wait_sweep("clear_sweep", 1'b1);
    rd_step(0, 0, 24'hAAAAAA, "clr_0_0");
    rd_step(639, 479, 24'hAAAAAA, "clr_639_479");
    rd_step(40, 20, 24'hAAAAAA, "clr_40_20");
    rd_step(640, 0, 24'h000000, "offscreen_x");
    rd_step(0, 480, 24'h000000, "offscreen_y");

    // Parser still aligned after the stalled bytes.
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h09);
    rd_step(8, 12, 24'h5555FF, "pal9_8_12");
    rd_step(11, 15, 24'h5555FF, "pal9_11_15");
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h04);
    rd_step(4, 4, 24'hAA0000, "pal4");
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h08);
    rd_step(8, 0, 24'h555555, "pal8");

    send_byte(8'h00); send_byte(8'h00);
    in_valid = 1'b1;
    in_data  = 8'h0F;
    rd(0, 0, 24'hAAAAAA, "collide_old");
    step(1);
    in_valid = 1'b0;
    rd_step(0, 0, 24'hFFFFFF, "collide_new");
    step(3);

    send_byte(8'h03); send_byte(8'h03);
    rd(0, 0, 24'hFFFFFF, "pre_reset_0_0");
    step(3);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rgb", {8'h0, r, g, b}, 32'h0);
    check("async_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_sweep("reset2_sweep", 1'b0);
    rd_step(12, 12, 24'h000000, "no_pending_write");
    rd_step(0, 0, 24'h000000, "reset2_0_0");
    rd_step(8, 0, 24'h000000, "reset2_8_0");
    step(4);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
